// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared combinational ALU, with a
// one-entry response register per requester. Define ALU_ARB_FIXED_PRIO_EN for fixed priority to port 0.
module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_code,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_code,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,

    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_data,
    input  logic         rsp0_ready,

    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_data,
    input  logic         rsp1_ready,

    output logic [3:0]   alu_code,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result
);

    typedef struct packed {
        logic [3:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } alu_op_t;

    logic         elig0, elig1;
    logic         grant0, grant1;
    alu_op_t      alu_op;

    logic         rsp0_valid_q, rsp0_valid_d;
    logic         rsp1_valid_q, rsp1_valid_d;
    logic [W-1:0] rsp0_data_q, rsp0_data_d;
    logic [W-1:0] rsp1_data_q, rsp1_data_d;

    // A port may only win when its response slot is free or being consumed now.
    // Gating with rst_n keeps ready and the ALU operands quiet during reset.
    always_comb begin
        elig0 = rst_n && req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1 = rst_n && req1_valid && (!rsp1_valid_q || rsp1_ready);
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = elig0;
        grant1 = elig1 && !elig0;
    end
`else
    // prio1_q set means port 1 is preferred on the next contended cycle.
    logic prio1_q, prio1_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        prio1_d = prio1_q;
        grant0  = elig0 && (!elig1 || !prio1_q);
        grant1  = elig1 && (!elig0 ||  prio1_q);
        if (grant0) begin
            prio1_d = 1'b1;
        end else if (grant1) begin
            prio1_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio1_q <= 1'b0;
        end else begin
            prio1_q <= prio1_d;
        end
    end
`endif

    always_comb begin
        alu_op = '0;
        if (grant0) begin
            alu_op = '{code: req0_code, a: req0_a, b: req0_b};
        end else if (grant1) begin
            alu_op = '{code: req1_code, a: req1_a, b: req1_b};
        end
    end

    assign alu_code   = alu_op.code;
    assign alu_a      = alu_op.a;
    assign alu_b      = alu_op.b;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // A fresh accept wins over a same-edge consume, so back-to-back traffic keeps valid high.
    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_result;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_result;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are cleared too, so a read after reset never shows stale results.
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a reference ALU closes the loop, and per-port
// scoreboard queues hold the expected results of predicted accepts.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_code, req1_code;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic         rsp0_ready, rsp1_ready;
    logic [3:0]   alu_code;
    logic [W-1:0] alu_a, alu_b, alu_result;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 clk = ~clk;

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_code(req0_code),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_code(req1_code),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );

    function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (c)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h9:    return {{(W-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_code, alu_a, alu_b);

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the rising edge, check on the falling edge.
    task automatic step(input string tag,
                        input logic v0, input logic [3:0] c0, input logic [W-1:0] a0,
                        input logic [W-1:0] b0, input logic rr0,
                        input logic v1, input logic [3:0] c1, input logic [W-1:0] a1,
                        input logic [W-1:0] b1, input logic rr1,
                        input logic e0, input logic e1);
        logic [3:0]   ec;
        logic [W-1:0] ea, eb;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_code = c0; req0_a = a0; req0_b = b0; rsp0_ready = rr0;
        req1_valid = v1; req1_code = c1; req1_a = a1; req1_b = b1; rsp1_ready = rr1;
        @(negedge clk);

        check({tag, ".rsp0_valid"}, W'(rsp0_valid), W'(q0.size() > 0));
        if (q0.size() > 0 && rsp0_valid) begin
            check({tag, ".rsp0_data"}, rsp0_data, q0[0]);
            if (rr0) void'(q0.pop_front());
        end
        check({tag, ".rsp1_valid"}, W'(rsp1_valid), W'(q1.size() > 0));
        if (q1.size() > 0 && rsp1_valid) begin
            check({tag, ".rsp1_data"}, rsp1_data, q1[0]);
            if (rr1) void'(q1.pop_front());
        end

        check({tag, ".req0_ready"}, W'(req0_ready), W'(e0));
        check({tag, ".req1_ready"}, W'(req1_ready), W'(e1));

        ec = '0; ea = '0; eb = '0;
        if (e0) begin
            ec = c0; ea = a0; eb = b0;
        end else if (e1) begin
            ec = c1; ea = a1; eb = b1;
        end
        check({tag, ".alu_code"}, W'(alu_code), W'(ec));
        check({tag, ".alu_a"}, alu_a, ea);
        check({tag, ".alu_b"}, alu_b, eb);

        if (e0) q0.push_back(alu_fn(c0, a0, b0));
        if (e1) q1.push_back(alu_fn(c1, a1, b1));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic exp0;
        // Reset held with both requests valid: nothing may be granted.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_code = 4'h0; req0_a = 32'd1; req0_b = 32'd2; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_code = 4'h0; req1_a = 32'd3; req1_b = 32'd4; rsp1_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst.req0_ready", W'(req0_ready), '0);
        check("rst.req1_ready", W'(req1_ready), '0);
        check("rst.alu_code", W'(alu_code), '0);
        check("rst.alu_a", alu_a, '0);
        check("rst.rsp0_valid", W'(rsp0_valid), '0);
        check("rst.rsp1_valid", W'(rsp1_valid), '0);
        check("rst.rsp0_data", rsp0_data, '0);
        check("rst.rsp1_data", rsp1_data, '0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        // Single add on port 0, result one cycle later.
        step("add", 1'b1, 4'h0, 32'd5, 32'd3, 1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 1'b0);
        idle("add_rsp");
        check("add.data8", rsp0_data, 32'd8);

        // Accept on port 0, then reset asserted mid-operation.
        step("pre_rst", 1'b1, 4'h4, 32'hFF, 32'h0F, 1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #2;
        check("mid_rst.rsp0_valid", W'(rsp0_valid), '0);
        check("mid_rst.rsp0_data", rsp0_data, '0);
        check("mid_rst.req0_ready", W'(req0_ready), '0);
        check("mid_rst.alu_a", alu_a, '0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        idle("post_rst");

        // Contention for four cycles; pointer starts at port 0 after reset.
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp0 = 1'b1;
`else
            exp0 = (i % 2 == 0);
`endif
            step($sformatf("rr%0d", i),
                 1'b1, 4'h0, 32'(i + 1), 32'd100, 1'b1,
                 1'b1, 4'h2, 32'hF0F0, 32'(32'h0FF0 + i), 1'b1,
                 exp0, !exp0);
        end
        idle("rr_drain");

        // Port 1 slot full and stalled: port 0 wins every cycle, rsp1 held.
        step("fill1", 1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 4'h3, 32'h1234, 32'h00FF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall%0d", i),
                 1'b1, 4'h1, 32'(50 + i), 32'd8, 1'b1,
                 1'b1, 4'h0, 32'd9, 32'd9, 1'b0,
                 1'b1, 1'b0);
        end
        check("stall.rsp1_data", rsp1_data, 32'h12FF);
`ifdef ALU_ARB_FIXED_PRIO_EN
        step("unstall", 1'b1, 4'h2, 32'h77, 32'h0F, 1'b1, 1'b1, 4'h0, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0);
`else
        step("unstall", 1'b1, 4'h2, 32'h77, 32'h0F, 1'b1, 1'b1, 4'h0, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1);
`endif

        // Back-to-back on port 1: subtract, set-less-than, unassigned code.
        step("sub", 1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 4'h1, 32'd2, 32'd7, 1'b1, 1'b0, 1'b1);
        step("slt", 1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 4'h9, 32'd2, 32'd7, 1'b1, 1'b0, 1'b1);
        check("sub.data", rsp1_data, 32'hFFFFFFFB);
        step("code_c", 1'b0, 4'h0, '0, '0, 1'b1, 1'b1, 4'hC, 32'd5, 32'd5, 1'b1, 1'b0, 1'b1);
        check("slt.data", rsp1_data, 32'd1);
        idle("code_c_rsp");
        check("code_c.data", rsp1_data, 32'd0);
        idle("final");
        check("final.q0_empty", W'(q0.size()), '0);
        check("final.q1_empty", W'(q1.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: reqN_valid  input  1  request N (N=0,1) offers an operation.
REQ-005 SHALL have ports: reqN_ready  output  1  request N accepted this cycle.
REQ-006 SHALL have ports: reqN_code  input  4  ALU operation code; reqN_a, reqN_b  input  W  operands.
REQ-007 SHALL have ports: rspN_valid  output  1  result held for requester N; rspN_data  output  W  result.
REQ-008 SHALL have ports: rspN_ready  input  1  requester N consumes its result.
REQ-009 SHALL have ports: alu_code  output  4, alu_a  output  W, alu_b  output  W; shared ALU operands.
REQ-010 SHALL have port: alu_result  input  W  combinational result of the shared ALU.

Function
REQ-011 SHALL grant at most one request per cycle; a request is accepted when reqN_valid=1 and reqN_ready=1.
REQ-012 SHALL raise reqN_ready only if N is granted and response slot N is empty or drains this cycle (rspN_valid=1, rspN_ready=1).
REQ-013 SHALL drive alu_code/alu_a/alu_b combinationally from the granted request; all zero when nothing is granted.
REQ-014 SHALL capture alu_result into rspN_data on the accepting edge; rspN_valid rises the next cycle (latency 1).
REQ-015 SHALL hold rspN_valid and rspN_data stable until rspN_ready=1; clear rspN_valid on the consuming edge unless a new accept for N occurs on the same edge.
REQ-016 SHALL arbitrate round-robin: when both eligible, grant the port not granted last; pointer updates only on an accept.
REQ-017 SHALL treat a port whose response slot is full and not draining as ineligible, and grant the other port.
REQ-018 SHALL pass reqN_code unchanged; codes 4'b1011-4'b1111 are forwarded, and the result is whatever the ALU returns (0 by default).
REQ-019 SHALL allow back-to-back accepts on the same port every cycle while rspN_ready stays 1.
REQ-020 SHALL not require reqN_valid to stay asserted; a deasserted request is simply not granted.

Reset
REQ-021 SHALL, on rst_n=0, asynchronously clear rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, and the round-robin pointer (next preferred = port 0).
REQ-022 SHALL hold reqN_ready=0 and alu_* = 0 while rst_n=0.
REQ-023 SHALL discard an in-flight accept or pending response when reset asserts mid-operation; no rspN_valid after release without a new accept.

Configuration
REQ-024 SHALL, with ALU_ARB_FIXED_PRIO_EN defined, grant port 0 whenever it is eligible (fixed priority; pointer unused).
REQ-025 SHALL, without ALU_ARB_FIXED_PRIO_EN, use the round-robin rule of REQ-016.

Verification
REQ-026 SHALL cover: after reset, req0 code=0000 a=5 b=3 -> req0_ready=1, next cycle rsp0_valid=1, rsp0_data=8.
REQ-027 SHALL cover: both valid for 4 cycles, rsp ready=1 -> grants alternate 0,1,0,1 (with macro: 0,0,0,0).
REQ-028 SHALL cover: rsp1_ready=0 with rsp1 full, both requesting -> port 0 granted every cycle, req1_ready=0, rsp1_data stable.
REQ-029 SHALL cover: req1 code=0001 a=2 b=7 -> rsp1_data=32'hFFFFFFFB; code=1001 same operands -> 1.
REQ-030 SHALL cover: rst_n pulsed low the cycle after an accept -> rspN_valid=0, pointer at port 0 after release.
